// File: rtl/regfile_sb.sv
// Register file with two write ports, two combinational read ports and a
// per-register pending scoreboard. Register 0 is hardwired to zero.
module regfile_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ra_addr,
    input  logic [ADDR_W-1:0] rb_addr,
    output logic [DATA_W-1:0] ra_data,
    output logic [DATA_W-1:0] rb_data,
    output logic              ra_busy,
    output logic              rb_busy,
    input  logic              we0,
    input  logic [ADDR_W-1:0] wa0,
    input  logic [DATA_W-1:0] wd0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] wa1,
    input  logic [DATA_W-1:0] wd1,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_addr,
    output logic [ADDR_W:0]   busy_cnt
);

    localparam int NREG = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic [NREG-1:0]   pending_q;
    logic [NREG-1:0]   pending_d;

    logic write0Ok;
    logic write1Ok;
    logic issueOk;

    assign write0Ok = we0 && (wa0 != '0);
    assign write1Ok = we1 && (wa1 != '0);
    assign issueOk  = iss_valid && (iss_addr != '0);

    // Port 1 is applied last so it wins a same-address conflict.
    always_comb begin
        regs_d = regs_q;
        if (write0Ok) begin
            regs_d[wa0] = wd0;
        end
        if (write1Ok) begin
            regs_d[wa1] = wd1;
        end
        regs_d[0] = '0;
    end

    // Writes retire a producer; an issue on the same edge re-arms the bit,
    // because the newly issued producer is still outstanding.
    always_comb begin
        pending_d = pending_q;
        if (write0Ok) begin
            pending_d[wa0] = 1'b0;
        end
        if (write1Ok) begin
            pending_d[wa1] = 1'b0;
        end
        if (issueOk) begin
            pending_d[iss_addr] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            pending_q <= '0;
        end else begin
            regs_q    <= regs_d;
            pending_q <= pending_d;
        end
    end

    // Both read ports share the same forwarding and busy logic.
    for (genvar p = 0; p < 2; p++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              busy;
        logic              hit0;
        logic              hit1;

        assign addr = (p == 0) ? ra_addr : rb_addr;

        always_comb begin
            hit0 = (BYPASS != 0) && we0 && (wa0 == addr);
            hit1 = (BYPASS != 0) && we1 && (wa1 == addr);
            data = regs_q[addr];
            if (hit1) begin
                data = wd1;
            end else if (hit0) begin
                data = wd0;
            end
            if (addr == '0) begin
                data = '0;
            end
            busy = pending_q[addr] && !(hit0 || hit1);
        end
    end

    assign ra_data = g_rd[0].data;
    assign rb_data = g_rd[1].data;
    assign ra_busy = g_rd[0].busy;
    assign rb_busy = g_rd[1].busy;

    // Bit 0 can never be set, so the count tops out at NREG-1 and cannot wrap.
    always_comb begin
        busy_cnt = '0;
        for (int i = 0; i < NREG; i++) begin
            busy_cnt = busy_cnt + (ADDR_W + 1)'(pending_q[i]);
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb; a bypassing and a
// non-bypassing instance share the same stimulus.
module tb_regfile_sb;

    logic        clk;
    logic        rst;
    logic [4:0]  ra_addr;
    logic [4:0]  rb_addr;
    logic        we0;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic        we1;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic        iss_valid;
    logic [4:0]  iss_addr;

    logic [31:0] raDataB, rbDataB, raDataN, rbDataN;
    logic        raBusyB, rbBusyB, raBusyN, rbBusyN;
    logic [5:0]  busyCntB, busyCntN;

    int checkCount;
    int failCount;

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) dutB (
        .clk(clk), .rst(rst), .ra_addr(ra_addr), .rb_addr(rb_addr),
        .ra_data(raDataB), .rb_data(rbDataB), .ra_busy(raBusyB), .rb_busy(rbBusyB),
        .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
        .iss_valid(iss_valid), .iss_addr(iss_addr), .busy_cnt(busyCntB)
    );

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) dutN (
        .clk(clk), .rst(rst), .ra_addr(ra_addr), .rb_addr(rb_addr),
        .ra_data(raDataN), .rb_data(rbDataN), .ra_busy(raBusyN), .rb_busy(rbBusyN),
        .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
        .iss_valid(iss_valid), .iss_addr(iss_addr), .busy_cnt(busyCntN)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic e0, input logic [4:0] a0, input logic [31:0] d0,
                                 input logic e1, input logic [4:0] a1, input logic [31:0] d1,
                                 input logic iv, input logic [4:0] ia);
        we0 = e0; wa0 = a0; wd0 = d0;
        we1 = e1; wa1 = a1; wd1 = d1;
        iss_valid = iv; iss_addr = ia;
    endtask

    task automatic applyIdle();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    endtask

    // Inputs change 1 time unit after the rising edge; combinational checks
    // follow 2 units later, well clear of the next edge.
    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checkCount = 0;
        failCount  = 0;
        ra_addr = 5'd0;
        rb_addr = 5'd0;

        // Reset held with a write and an issue pending on the inputs
        rst = 1'b0;
        applyStimulus(1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3);
        ra_addr = 5'd3;
        stepClock();
        stepClock();
        #2;
        checkOutput("rst_cnt_held", busyCntB, 6'd0);
        applyIdle();
        rst = 1'b1;
        #2;
        checkOutput("rst_r3_data", raDataB, 32'h0);
        checkOutput("rst_r3_busy", raBusyB, 1'b0);
        checkOutput("rst_cnt", busyCntB, 6'd0);
        checkOutput("rst_r3_data_nb", raDataN, 32'h0);
        stepClock();

        // Dual-write conflict on r7
        applyStimulus(1'b1, 5'd7, 32'h11, 1'b1, 5'd7, 32'h22, 1'b0, 5'd0);
        ra_addr = 5'd7;
        #2;
        checkOutput("dual_fwd_byp", raDataB, 32'h22);
        checkOutput("dual_fwd_nobyp", raDataN, 32'h0);
        stepClock();
        applyIdle();
        #2;
        checkOutput("dual_r7_byp", raDataB, 32'h22);
        checkOutput("dual_r7_nobyp", raDataN, 32'h22);
        stepClock();

        // Port-0 bypass on r5, rb port reading r7
        applyStimulus(1'b1, 5'd5, 32'hA5A5A5A5, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        ra_addr = 5'd5;
        rb_addr = 5'd7;
        #2;
        checkOutput("byp_same_cycle", raDataB, 32'hA5A5A5A5);
        checkOutput("nobyp_old_value", raDataN, 32'h0);
        checkOutput("rb_r7", rbDataB, 32'h22);
        stepClock();
        applyIdle();
        #2;
        checkOutput("nobyp_next_cycle", raDataN, 32'hA5A5A5A5);
        stepClock();

        // Scoreboard sequence on r9
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9);
        ra_addr = 5'd9;
        rb_addr = 5'd9;
        stepClock();
        applyIdle();
        #2;
        checkOutput("sb_issue_busy", raBusyB, 1'b1);
        checkOutput("sb_issue_rbbusy", rbBusyN, 1'b1);
        checkOutput("sb_issue_cnt", busyCntB, 6'd1);
        stepClock();
        applyStimulus(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9);
        #2;
        checkOutput("sb_fwd_busy_byp", raBusyB, 1'b0);
        checkOutput("sb_fwd_busy_nobyp", raBusyN, 1'b1);
        stepClock();
        applyIdle();
        #2;
        checkOutput("sb_reissue_busy", raBusyB, 1'b1);
        checkOutput("sb_reissue_cnt", busyCntB, 6'd1);
        checkOutput("sb_reissue_data", raDataN, 32'h99);
        stepClock();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h77, 1'b0, 5'd0);
        stepClock();
        applyIdle();
        #2;
        checkOutput("sb_clear_cnt", busyCntB, 6'd0);
        checkOutput("sb_clear_busy", rbBusyB, 1'b0);
        checkOutput("sb_clear_data", rbDataB, 32'h77);
        stepClock();

        // Register 0 is immune to issues and writes
        applyStimulus(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0);
        ra_addr = 5'd0;
        #2;
        checkOutput("r0_fwd_data", raDataB, 32'h0);
        stepClock();
        applyIdle();
        #2;
        checkOutput("r0_data", raDataB, 32'h0);
        checkOutput("r0_data_nb", raDataN, 32'h0);
        checkOutput("r0_busy", raBusyB, 1'b0);
        checkOutput("r0_cnt", busyCntB, 6'd0);

        // Fill the scoreboard r1..r31
        for (int i = 1; i < 32; i++) begin
            applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'(i));
            stepClock();
            applyIdle();
            #2;
            checkOutput($sformatf("fill_cnt_%0d", i), busyCntB, 6'(i));
        end
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5);
        stepClock();
        applyIdle();
        #2;
        checkOutput("reissue_noop_cnt", busyCntB, 6'd31);

        // Drain two registers per edge, the last edge retiring only r31
        for (int i = 1; i < 32; i += 2) begin
            applyStimulus(1'b1, 5'(i), 32'h100 + 32'(i),
                          (i + 1 < 32), 5'((i + 1) % 32), 32'h200 + 32'(i + 1),
                          1'b0, 5'd0);
            stepClock();
            applyIdle();
            #2;
            checkOutput($sformatf("drain_cnt_%0d", i), busyCntB,
                        6'((i + 1 < 32) ? (31 - (i + 1)) : 0));
        end
        ra_addr = 5'd7;
        rb_addr = 5'd8;
        #1;
        checkOutput("drain_r7", raDataB, 32'h107);
        checkOutput("drain_r8", rbDataN, 32'h208);
        stepClock();

        // Reset mid-operation with a producer outstanding
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4);
        stepClock();
        applyIdle();
        #2;
        checkOutput("mid_cnt_before", busyCntB, 6'd1);
        rst = 1'b0;
        #1;
        checkOutput("mid_cnt_reset", busyCntB, 6'd0);
        checkOutput("mid_r7_reset", raDataB, 32'h0);
        ra_addr = 5'd4;
        #1;
        checkOutput("mid_r4_busy", raBusyN, 1'b0);
        stepClock();
        rst = 1'b1;
        stepClock();

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32: width of each register and of every data port.
REQ-002 The block SHALL have parameter ADDR_W, default 5: register address width; the register count is 2^ADDR_W.
REQ-003 The block SHALL have parameter BYPASS, default 1: 1 enables same-cycle write-to-read forwarding; 0 disables it.
REQ-004 The block SHALL have port clk, input, width 1: single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, width 1: asynchronous, active-low reset.
REQ-006 The block SHALL have ports ra_addr and rb_addr, input, width ADDR_W: read port A and B addresses.
REQ-007 The block SHALL have ports ra_data and rb_data, output, width DATA_W: read data, combinational.
REQ-008 The block SHALL have ports ra_busy and rb_busy, output, width 1: the addressed register has an outstanding producer.
REQ-009 The block SHALL have ports we0, wa0 and wd0, input, widths 1, ADDR_W and DATA_W: write port 0 (ALU writeback).
REQ-010 The block SHALL have ports we1, wa1 and wd1, input, widths 1, ADDR_W and DATA_W: write port 1 (load writeback).
REQ-011 The block SHALL have ports iss_valid and iss_addr, input, widths 1 and ADDR_W: issue marks destination iss_addr pending.
REQ-012 The block SHALL have port busy_cnt, output, width ADDR_W+1: number of pending registers.

Function
REQ-013 The block SHALL hardwire register 0: reads return 0, writes are ignored, the pending bit stays 0 and ra_busy/rb_busy stay 0 for address 0.
REQ-014 The block SHALL write wd0 to register wa0 on the rising edge when we0=1 and wa0!=0; port 1 behaves likewise with we1, wa1 and wd1.
REQ-015 The block SHALL let port 1 win when both write ports are enabled with the same nonzero address: wd1 is stored.
REQ-016 The block SHALL return register[addr] combinationally on each read port when BYPASS=0, with a write becoming visible the cycle after its edge.
REQ-017 The block SHALL forward in-flight write data when BYPASS=1: read data = wd1 if we1 and wa1 match the read address, else wd0 if we0 and wa0 match, else the stored value; address 0 always returns 0.
REQ-018 The block SHALL clear the pending bit of a nonzero written address on the same edge as the write (either port).
REQ-019 The block SHALL set the pending bit of iss_addr on the rising edge when iss_valid=1 and iss_addr!=0.
REQ-020 The block SHALL give set priority when an issue and a write target the same register on one edge: the bit ends at 1, because the newer producer is outstanding.
REQ-021 The block SHALL treat an issue to an already-pending register as a no-op on the pending vector.
REQ-022 The block SHALL drive ra_busy = pending[ra_addr]; when BYPASS=1 it SHALL be forced to 0 if a same-cycle write matches ra_addr. rb_busy SHALL behave likewise.
REQ-023 The block SHALL make busy_cnt equal the population count of the pending vector after each edge; its range is 0 to 2^ADDR_W-1 and it SHALL never wrap.
REQ-024 The block SHALL have no handshake or back-pressure: all writes and issues are accepted unconditionally.

Reset
REQ-025 The block SHALL, while rst=0, asynchronously clear every register to 0 and every pending bit to 0, giving busy_cnt=0.
REQ-026 The block SHALL ignore writes and issues while rst=0; on release, the first rising edge with rst=1 SHALL process inputs normally.
REQ-027 The block SHALL discard all state on reset asserted mid-operation (pending producers, partial writes) with no residual busy indications.

Verification
REQ-028 Reset check: drive rst=0 with we0=1, wa0=3, wd0=0xDEADBEEF, then release and read r3 -> ra_data=0, ra_busy=0, busy_cnt=0.
REQ-029 Dual-write conflict: we0=we1=1, wa0=wa1=7, wd0=0x11, wd1=0x22, then next cycle read r7 -> 0x22.
REQ-030 Bypass check with BYPASS=1: in the cycle that we0=1, wa0=5, wd0=0xA5A5A5A5 and ra_addr=5 -> ra_data=0xA5A5A5A5 in that same cycle; with BYPASS=0 -> old value in that cycle, then 0xA5A5A5A5 next cycle.
REQ-031 Scoreboard check: issue r9 -> ra_busy(9)=1 and busy_cnt=1; then write r9 while issuing r9 on the same edge -> r9 stays pending and busy_cnt=1; then write r9 alone -> busy_cnt=0.
REQ-032 Register-0 check: issue r0 and write r0 with 0xFFFFFFFF -> ra_data(0)=0, ra_busy=0, busy_cnt unchanged.
REQ-033 Full-occupancy check: issue r1 through r31 on consecutive edges -> busy_cnt=31; then clear all via both write ports -> busy_cnt steps down to 0 with no wrap.
